gate_array_seq: RTL and testbench

- Parametrised, registered successor to the single-bit GATES block: a WIDTH-bit bitwise logic unit with eight selectable operations.
- Accepts operands through a valid/ready handshake and presents a registered result.
- Contains a built-in exhaustive truth-table sweep engine for on-chip self-check.
- Sits between operand producers and downstream consumers in lab datapaths; the sweep replaces the stimulus a bench would otherwise drive by hand.

---
 rtl/gate_array_seq_if.sv | 24 ++
 rtl/gate_array_seq.sv | 126 ++++++++++++
 tb/tb_gate_array_seq.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/gate_array_seq_if.sv
// Operand/result handshake bundle for gate_array_seq.
// The master drives operands and consumes results.
interface gate_array_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/gate_array_seq.sv
// WIDTH-bit registered bitwise logic unit with eight operations
// and a built-in 32-vector truth-table sweep producing a signature.
module gate_array_seq #(
  parameter int WIDTH = 8,
  parameter int SIG_W = $clog2(32*WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  gate_array_seq_if.slave  bus,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done,
  output logic [SIG_W-1:0] sweep_sig
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  function automatic logic [WIDTH-1:0] f_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    unique case (1'b1)
      (op == 3'd0): r = a & b;
      (op == 3'd1): r = a | b;
      (op == 3'd2): r = a ^ b;
      (op == 3'd3): r = ~(a & b);
      (op == 3'd4): r = ~(a | b);
      (op == 3'd5): r = ~(a ^ b);
      (op == 3'd6): r = ~a;
      (op == 3'd7): r = a & ~b;
    endcase
    return r;
  endfunction

  function automatic logic [SIG_W-1:0] popcnt(
    input logic [WIDTH-1:0] v
  );
    logic [SIG_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      r = r + SIG_W'(v[i]);
    return r;
  endfunction

  state_t           r_state;
  state_t           w_next;
  logic [4:0]       r_k;
  logic [SIG_W-1:0] r_sig;
  logic [WIDTH-1:0] r_y;
  logic             r_vld;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_drain;
  logic             w_start;
  logic [WIDTH-1:0] w_sw_y;
  logic [WIDTH-1:0] w_y;

  assign w_in_ready = (r_state == S_IDLE) && !sweep_start
                    && (!r_vld || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_drain    = r_vld && bus.out_ready;
  // A pending result blocks sweep entry so y stays coherent.
  assign w_start    = (r_state == S_IDLE) && sweep_start && !r_vld;

  assign w_y    = f_op(bus.op, bus.a, bus.b);
  assign w_sw_y = f_op(r_k[4:2], {WIDTH{r_k[1]}}, {WIDTH{r_k[0]}});

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_start) w_next = S_SWEEP;
      S_SWEEP: if (r_k == 5'd31) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y   <= '0;
      r_vld <= 1'b0;
    end else if (w_accept) begin
      r_y   <= w_y;
      r_vld <= 1'b1;
    end else if (w_drain) begin
      r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_sig <= '0;
    end else if (w_start) begin
      r_k   <= '0;
      r_sig <= '0;
    end else if (r_state == S_SWEEP) begin
      r_k   <= r_k + 5'd1;
      r_sig <= r_sig + popcnt(w_sw_y);
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld;
  assign bus.y         = r_y;
  assign sweep_busy    = (r_state == S_SWEEP);
  assign sweep_done    = (r_state == S_DONE);
  assign sweep_sig     = r_sig;

endmodule

// File: tb/tb_gate_array_seq.sv
// Randomised and directed bench for gate_array_seq against a
// truth-table based cycle model.
module tb_gate_array_seq;
  localparam int W     = 8;
  localparam int SIG_W = $clog2(32*W+1);
  localparam logic [31:0] TT = {4'b0100, 4'b0011, 4'b1001, 4'b0001,
                                4'b0111, 4'b0110, 4'b1110, 4'b1000};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ss = 1'b0;
  logic busy, done;
  logic [SIG_W-1:0] sig;

  gate_array_seq_if #(.WIDTH(W)) bus ();

  gate_array_seq #(.WIDTH(W)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .sweep_start (ss),
    .sweep_busy  (busy),
    .sweep_done  (done),
    .sweep_sig   (sig)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int busy_cnt = 0;

  logic [W-1:0] m_y;
  logic         m_vld;
  int           m_st;
  int           m_k;
  int           m_sig;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_f(input int op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [31:0]  t;
    logic [W-1:0] r;
    t = TT;
    for (int i = 0; i < W; i++)
      r[i] = t[op*4 + 2*int'(a[i]) + int'(b[i])];
    return r;
  endfunction

  task automatic m_reset();
    m_y = '0; m_vld = 1'b0; m_st = 0; m_k = 0; m_sig = 0;
  endtask

  task automatic step(input logic iv, input int op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy, input logic s);
    logic exp_rdy;
    logic pre_vld;
    bus.in_valid = iv; bus.op = 3'(op); bus.a = a; bus.b = b;
    bus.out_ready = ordy; ss = s;
    #1;
    exp_rdy = (m_st == 0) && !s && (!m_vld || ordy);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
    @(posedge clk);
    pre_vld = m_vld;
    if (iv && exp_rdy) begin
      m_y = ref_f(op, a, b); m_vld = 1'b1;
    end else if (m_vld && ordy) begin
      m_vld = 1'b0;
    end
    case (m_st)
      0: if (s && !pre_vld) begin m_st = 1; m_k = 0; m_sig = 0; end
      1: begin
        m_sig += $countones(ref_f(m_k / 4, {W{m_k[1]}}, {W{m_k[0]}}));
        if (m_k == 31) m_st = 2; else m_k++;
      end
      default: m_st = 0;
    endcase
    #1;
    chk("out_valid", 32'(bus.out_valid), 32'(m_vld));
    chk("y", 32'(bus.y), 32'(m_y));
    chk("busy", 32'(busy), 32'(m_st == 1));
    chk("done", 32'(done), 32'(m_st == 2));
    chk("sig", 32'(sig), 32'(m_sig));
    if (done) done_cnt++;
    if (busy) busy_cnt++;
  endtask

  logic [W-1:0] seqv [8] = '{8'hC0, 8'hFC, 8'h3C, 8'h3F,
                             8'h03, 8'hC3, 8'h0F, 8'h30};

  initial begin
    bus.in_valid = 0; bus.op = 0; bus.a = 0; bus.b = 0;
    bus.out_ready = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_vld", 32'(bus.out_valid), 0);
    chk("rst_y", 32'(bus.y), 0);
    chk("rst_sig", 32'(sig), 0);

    // back-to-back ops on F0/CC
    for (int op = 0; op < 8; op++) begin
      step(1, op, 8'hF0, 8'hCC, 1, 0);
      chk("seq_y", 32'(bus.y), 32'(seqv[op]));
      chk("seq_vld", 32'(bus.out_valid), 1);
    end
    step(0, 0, 0, 0, 1, 0);

    // stall then drain with a pending beat
    step(1, 2, 8'hA5, 8'h0F, 0, 0);
    repeat (3) step(1, 1, 8'h12, 8'h21, 0, 0);
    chk("stall_y", 32'(bus.y), 32'h000000AA);
    step(1, 1, 8'h12, 8'h21, 1, 0);
    chk("drain_y", 32'(bus.y), 32'h00000033);
    step(0, 0, 0, 0, 1, 0);
    chk("drain_vld", 32'(bus.out_valid), 0);

    // plain sweep
    done_cnt = 0; busy_cnt = 0;
    step(0, 0, 0, 0, 1, 1);
    repeat (34) step(0, 0, 0, 0, 1, 0);
    chk("sw_done_cnt", 32'(done_cnt), 1);
    chk("sw_busy_cnt", 32'(busy_cnt), 32);
    chk("sw_sig", 32'(sig), 32'(15*W));
    chk("sw_y_kept", 32'(bus.y), 32'h00000033);

    // sweep_start during stall is ignored
    step(1, 0, 8'hFF, 8'h0F, 0, 0);
    busy_cnt = 0;
    repeat (2) step(0, 0, 0, 0, 0, 1);
    chk("stall_nobusy", 32'(busy_cnt), 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    chk("late_busy", 32'(busy), 1);
    repeat (34) step(0, 0, 0, 0, 1, 0);

    // reset at vector k=10
    done_cnt = 0;
    step(0, 0, 0, 0, 1, 1);
    repeat (10) step(0, 0, 0, 0, 1, 0);
    chk("pre_rst_k", 32'(m_k), 10);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_busy", 32'(busy), 0);
    chk("arst_sig", 32'(sig), 0);
    chk("arst_y", 32'(bus.y), 0);
    chk("arst_done", 32'(done), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(0, 0, 0, 0, 1, 1);
    repeat (34) step(0, 0, 0, 0, 1, 0);
    chk("rst_done_cnt", 32'(done_cnt), 1);
    chk("rst_sig2", 32'(sig), 32'(15*W));

    // beat offered alongside accepted sweep_start
    step(1, 7, 8'hF0, 8'hCC, 1, 1);
    chk("ss_beat_vld", 32'(bus.out_valid), 0);
    repeat (33) step(1, 7, 8'hF0, 8'hCC, 1, 0);
    step(1, 7, 8'hF0, 8'hCC, 1, 0);
    chk("after_done_y", 32'(bus.y), 32'h00000030);
    step(0, 0, 0, 0, 1, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), int'($urandom_range(0, 7)), W'($urandom),
           W'($urandom), 1'($urandom_range(0, 3) != 0),
           $urandom_range(0, 24) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
